// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the data-memory arbiter.
//   owner_t      : which requester the read data of the previous cycle belongs to
//   MAX_WAIT_DEF : default number of denied cycles before the peripheral wins
package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 16;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_PER  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arb_req_if: one requester port of the memory arbiter.
//   req/we/addr/wdata : request, held stable by the requester until gnt
//   gnt               : access accepted on the coming rising edge
//   rvalid/rdata      : read return, one cycle after the granted read
// master = requester side, slave = arbiter side.
interface mem_arb_req_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter_wait_counter.sv
// arb_wait_counter: saturating 4-bit count of consecutive denied peripheral cycles.
//   clk, rst  : clock, async active-low reset
//   inc       : count one more denied cycle (stops at limit)
//   clr       : restart from zero (takes priority over inc)
//   limit     : saturation value
//   at_limit  : count has reached limit
module arb_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic [3:0] limit,
  output logic       at_limit
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else if (clr) begin
      cnt_q <= 4'd0;
    end else if (inc && (cnt_q < limit)) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign at_limit = (cnt_q >= limit);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port synchronous-read memory between the CPU
// (fixed priority) and a peripheral master (anti-starvation after MAX_WAIT
// denied cycles). Read data is routed back by an owner register.
//   clk, rst            : clock, async active-low reset
//   cpu, per            : requester ports (mem_arb_req_if.slave)
//   mem_addr/wdata/we   : memory port, driven by the granted requester
//   mem_rdata           : memory read data, one cycle after the address
//
// owner_q state | meaning
// OWN_NONE      | no read in flight, both rvalid low
// OWN_CPU       | CPU read granted last cycle, mem_rdata belongs to CPU
// OWN_PER       | peripheral read granted last cycle, mem_rdata belongs to peripheral
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_arb_req_if.slave      cpu,
  mem_arb_req_if.slave      per,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

  logic   cpu_gnt;
  logic   per_gnt;
  logic   per_at_limit;
  logic   per_denied;
  owner_t owner_q;

  // Peripheral only overrides the CPU once it has been denied LIMIT times in a row.
  assign cpu_gnt    = cpu.req & ~(per.req & per_at_limit);
  assign per_gnt    = per.req & ~cpu_gnt;
  assign per_denied = per.req & ~per_gnt;

  assign cpu.gnt = cpu_gnt;
  assign per.gnt = per_gnt;

  arb_wait_counter u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (per_denied),
    .clr      (~per_denied),
    .limit    (LIMIT),
    .at_limit (per_at_limit)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu.addr;
      mem_wdata = cpu.wdata;
      mem_we    = cpu.we;
    end else if (per_gnt) begin
      mem_addr  = per.addr;
      mem_wdata = per.wdata;
      mem_we    = per.we;
    end
    // Requests are still arbitrated in reset, but the memory must never be written.
    if (!rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
    end else if (cpu_gnt && !cpu.we) begin
      owner_q <= OWN_CPU;
    end else if (per_gnt && !per.we) begin
      owner_q <= OWN_PER;
    end else begin
      owner_q <= OWN_NONE;
    end
  end

  assign cpu.rvalid = (owner_q == OWN_CPU);
  assign per.rvalid = (owner_q == OWN_PER);
  assign cpu.rdata  = (owner_q == OWN_CPU) ? mem_rdata : '0;
  assign per.rdata  = (owner_q == OWN_PER) ? mem_rdata : '0;

endmodule
